seven_display_scan: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds DIGITS hex nibbles and shares one seven_display decoder across all digits.
- Drives one anode at a time, with a blanking gap between digits to prevent ghosting.
- Sits between the register/bus side (load strobe) and the board pins (segments, dp, anodes).

---
 rtl/seven_display_pkg.sv | 26 ++
 rtl/seven_display.sv | 33 +++
 rtl/seven_display_scan.sv | 195 +++++++++++++++++++
 tb/tb_seven_display_scan.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_display_pkg.sv
// Shared constants, state encoding and parameter range checks for the
// seven-segment scan controller.
package seven_display_pkg;

    // All segments dark on an active-low common-anode display.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    function automatic bit digits_legal(input int digits);
        return (digits >= 1) && (digits <= 8);
    endfunction

    function automatic bit blank_legal(input int blank_cycles);
        return blank_cycles >= 1;
    endfunction

    function automatic bit clk_div_legal(input int clk_div, input int blank_cycles);
        return clk_div >= (blank_cycles + 1);
    endfunction

endpackage

// File: rtl/seven_display.sv
// Hex nibble to active-low segment decoder, segments a..g with a in the MSB.
module seven_display
    import seven_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup from nibble value to the lit segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_display_scan.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
// Each digit slot is a short all-anodes-off blanking gap followed by a drive
// phase; the displayed value only changes at frame boundaries so a frame
// never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_display_scan
    import seven_display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    if (!digits_legal(DIGITS)) begin : g_bad_digits
        $error("seven_display_scan: DIGITS must be 1..8");
    end
    if (!blank_legal(BLANK_CYCLES)) begin : g_bad_blank
        $error("seven_display_scan: BLANK_CYCLES must be at least 1");
    end
    if (!clk_div_legal(CLK_DIV, BLANK_CYCLES)) begin : g_bad_div
        $error("seven_display_scan: CLK_DIV must exceed BLANK_CYCLES");
    end

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic                 frame_end;

    logic [4*DIGITS-1:0]  shadow_data, active_data;
    logic [DIGITS-1:0]    shadow_dp, active_dp;

    logic [3:0]           cur_nibble;
    logic                 cur_dp;
    logic                 cur_blank;
    logic [6:0]           dec_seg;
    logic [6:0]           seg_reg;
    logic                 dp_reg;

    seven_display u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Scan sequencer state, slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic: blank gap, drive phase, then advance to the next digit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        frame_end  = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
                S_BLANK: begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        state_next = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = S_BLANK;
                        if (idx == IDX_LAST) begin
                            idx_next  = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Shadow captures every load; active only moves at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_dp   <= '0;
        end else begin
            if (load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
            if (frame_end) begin
                active_data <= load ? data_in : shadow_data;
                active_dp   <= load ? dp_in   : shadow_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
`endif

    // Pick the active nibble and dp for the current digit, plus its blank flag.
    always_comb begin
        cur_nibble = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_run   = 1'b1;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            zero_run = zero_run && (active_data[4*k +: 4] == 4'd0);
`endif
            if (idx == IDX_W'(k)) begin
                cur_nibble = active_data[4*k +: 4];
                cur_dp     = active_dp[k];
`ifdef LEADING_ZERO_BLANK_EN
                cur_blank  = (k > 0) && zero_run;
`endif
            end
        end
    end

    // Segment/dp pins are loaded during the blank gap and held through drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
        end else if (state_next == S_IDLE) begin
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
        end else if (state == S_BLANK) begin
            seg_reg <= cur_blank ? SEG_BLANK : dec_seg;
            dp_reg  <= ~cur_dp;
        end
    end

    // Exactly one anode low, and only while driving.
    always_comb begin
        an_out = '1;
        if (state == S_DRIVE) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx == IDX_W'(k)) begin
                    an_out[k] = 1'b0;
                end
            end
        end
    end

    assign seg_out    = seg_reg;
    assign dp_out     = dp_reg;
    assign frame_done = frame_end & ~rst;

endmodule

// File: tb/tb_seven_display_scan.sv
// Self-checking bench for seven_display_scan (DIGITS=4, CLK_DIV=8,
// BLANK_CYCLES=2). The reference model tracks the position inside a frame
// as a plain cycle number and derives pins from it arithmetically.
module tb_seven_display_scan;

    localparam int DIGITS       = 4;
    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model: pos = -1 when idle, else cycle number within the frame.
    int          pos;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_shadow_dp, m_active_dp;

    logic [6:0] hex_seg [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_display_scan #(
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic bit in_drive();
        return (pos >= 0) && ((pos % CLK_DIV) >= BLANK_CYCLES);
    endfunction

    function automatic logic [3:0] exp_an();
        if (!in_drive()) return 4'b1111;
        return ~(4'b0001 << (pos / CLK_DIV));
    endfunction

    function automatic logic [6:0] exp_seg();
        int slot;
        if (pos < 0) return 7'b1111111;
        slot = pos / CLK_DIV;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_active >> (4 * slot)) == 16'd0) return 7'b1111111;
`endif
        return hex_seg[4'(m_active >> (4 * slot))];
    endfunction

    function automatic logic exp_dp();
        if (pos < 0) return 1'b1;
        return ~m_active_dp[pos / CLK_DIV];
    endfunction

    function automatic logic exp_fd();
        return (pos == FRAME - 1) && enable && !rst;
    endfunction

    // Advance one clock: model applies the same inputs the DUT samples.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            pos = -1;
            m_shadow = '0; m_shadow_dp = '0;
            m_active = '0; m_active_dp = '0;
        end else begin
            if (enable && pos == FRAME - 1) begin
                m_active    = load ? data_in : m_shadow;
                m_active_dp = load ? dp_in   : m_shadow_dp;
            end
            if (load) begin
                m_shadow    = data_in;
                m_shadow_dp = dp_in;
            end
            if (!enable)       pos = -1;
            else if (pos < 0)  pos = 0;
            else               pos = (pos + 1) % FRAME;
        end
        @(negedge clk);
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 2 * FRAME && pos != target; i++) tick();
        checks++;
        if (pos != target) begin
            errors++;
            $display("[TB] FAIL advance_to: position %0d, wanted %0d", pos, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; load = 1'b1;
        data_in = 16'($urandom); dp_in = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 4;
            if (an_out !== 4'b1111)     begin errors++; $display("[TB] FAIL reset an_out: got %b want 1111", an_out); end
            if (seg_out !== 7'b1111111) begin errors++; $display("[TB] FAIL reset seg_out: got %b want 1111111", seg_out); end
            if (dp_out !== 1'b1)        begin errors++; $display("[TB] FAIL reset dp_out: got %b want 1", dp_out); end
            if (frame_done !== 1'b0)    begin errors++; $display("[TB] FAIL reset frame_done: got %b want 0", frame_done); end
        end
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 2;
            if (an_out !== exp_an())      begin errors++; $display("[TB] FAIL startup an_out pos=%0d: got %b want %b", pos, an_out, exp_an()); end
            if (frame_done !== exp_fd())  begin errors++; $display("[TB] FAIL startup frame_done pos=%0d: got %b want %b", pos, frame_done, exp_fd()); end
        end
    endtask

    task automatic test_scan();
        load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0100;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks += 2;
            if (an_out !== exp_an())     begin errors++; $display("[TB] FAIL scan an_out pos=%0d: got %b want %b", pos, an_out, exp_an()); end
            if (frame_done !== exp_fd()) begin errors++; $display("[TB] FAIL scan frame_done pos=%0d: got %b want %b", pos, frame_done, exp_fd()); end
            if (in_drive()) begin
                checks += 2;
                if (seg_out !== exp_seg()) begin errors++; $display("[TB] FAIL scan seg_out pos=%0d: got %b want %b", pos, seg_out, exp_seg()); end
                if (dp_out !== exp_dp())   begin errors++; $display("[TB] FAIL scan dp_out pos=%0d: got %b want %b", pos, dp_out, exp_dp()); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        advance_to(FRAME - 2);
        load = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
        tick();
        load = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL last-cycle frame_done: got %b want 1", frame_done); end
        load = 1'b1; data_in = 16'($urandom); dp_in = 4'($urandom);
        tick();
        load = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (frame_done === 1'b1) pulses++;
            if (in_drive()) begin
                checks += 2;
                if (seg_out !== exp_seg()) begin errors++; $display("[TB] FAIL b2b seg_out pos=%0d: got %b want %b", pos, seg_out, exp_seg()); end
                if (dp_out !== exp_dp())   begin errors++; $display("[TB] FAIL b2b dp_out pos=%0d: got %b want %b", pos, dp_out, exp_dp()); end
            end
            tick();
        end
        checks++;
        if (pulses != 2) begin errors++; $display("[TB] FAIL frame_done pulse count: got %0d want 2", pulses); end
    endtask

    task automatic test_enable_toggle();
        advance_to(2 * CLK_DIV + 4);
        enable = 1'b0;
        tick();
        checks += 3;
        if (an_out !== 4'b1111)     begin errors++; $display("[TB] FAIL disable an_out: got %b want 1111", an_out); end
        if (seg_out !== 7'b1111111) begin errors++; $display("[TB] FAIL disable seg_out: got %b want 1111111", seg_out); end
        if (dp_out !== 1'b1)        begin errors++; $display("[TB] FAIL disable dp_out: got %b want 1", dp_out); end
        tick(); tick();
        enable = 1'b1;
        for (int i = 0; i < CLK_DIV + 3; i++) begin
            tick();
            checks++;
            if (an_out !== exp_an()) begin errors++; $display("[TB] FAIL reenable an_out pos=%0d: got %b want %b", pos, an_out, exp_an()); end
        end
    endtask

    task automatic test_reset_mid();
        advance_to(CLK_DIV + 3);
        rst = 1'b1; load = 1'b1; data_in = 16'hBEEF; dp_in = 4'b1111;
        tick();
        checks += 4;
        if (an_out !== 4'b1111)     begin errors++; $display("[TB] FAIL midreset an_out: got %b want 1111", an_out); end
        if (seg_out !== 7'b1111111) begin errors++; $display("[TB] FAIL midreset seg_out: got %b want 1111111", seg_out); end
        if (dp_out !== 1'b1)        begin errors++; $display("[TB] FAIL midreset dp_out: got %b want 1", dp_out); end
        if (frame_done !== 1'b0)    begin errors++; $display("[TB] FAIL midreset frame_done: got %b want 0", frame_done); end
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            tick();
            if (in_drive()) begin
                checks += 2;
                if (seg_out !== exp_seg()) begin errors++; $display("[TB] FAIL postreset seg_out pos=%0d: got %b want %b", pos, seg_out, exp_seg()); end
                if (dp_out !== exp_dp())   begin errors++; $display("[TB] FAIL postreset dp_out pos=%0d: got %b want %b", pos, dp_out, exp_dp()); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            load    = ($urandom_range(0, 5) == 0);
            data_in = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in   = 4'($urandom);
            if ($urandom_range(0, 60) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            rst = ($urandom_range(0, 250) == 0);
            tick();
            checks += 2;
            if (an_out !== exp_an())     begin errors++; $display("[TB] FAIL random an_out pos=%0d: got %b want %b", pos, an_out, exp_an()); end
            if (frame_done !== exp_fd()) begin errors++; $display("[TB] FAIL random frame_done pos=%0d: got %b want %b", pos, frame_done, exp_fd()); end
            if (in_drive() || pos < 0) begin
                checks += 2;
                if (seg_out !== exp_seg()) begin errors++; $display("[TB] FAIL random seg_out pos=%0d: got %b want %b", pos, seg_out, exp_seg()); end
                if (dp_out !== exp_dp())   begin errors++; $display("[TB] FAIL random dp_out pos=%0d: got %b want %b", pos, dp_out, exp_dp()); end
            end
        end
        rst = 1'b0; load = 1'b0; enable = 1'b1;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        logic [6:0] want [4];
        want[0] = 7'b0000001; want[1] = 7'b0000110;
        want[2] = 7'b1111111; want[3] = 7'b1111111;
        load = 1'b1; data_in = 16'h0030; dp_in = 4'b1000;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) tick();
        for (int i = 0; i < FRAME; i++) begin
            if (in_drive() && m_active == 16'h0030) begin
                checks++;
                if (seg_out !== want[pos / CLK_DIV]) begin errors++; $display("[TB] FAIL lzb seg_out digit=%0d: got %b want %b", pos / CLK_DIV, seg_out, want[pos / CLK_DIV]); end
            end
            tick();
        end
    endtask
`endif

    initial begin
        pos = -1;
        m_shadow = '0; m_shadow_dp = '0; m_active = '0; m_active_dp = '0;
        rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
        test_reset();
        test_scan();
        test_back_to_back();
        test_enable_toggle();
        test_reset_mid();
        test_random();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
